// File: rtl/huff_code_gen.sv
// rtl/huff_code_gen.sv - Huffman code generator: tree build, depth walk, canonical codes, emit
module huff_code_gen #(
  parameter int NUM_SYM = 4,
  parameter int SYM_W   = 8,
  parameter int FREQ_W  = 8,
  parameter int MAX_LEN = NUM_SYM - 1,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SYM_W-1:0]   in_sym,
  input  logic [FREQ_W-1:0]  in_freq,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SYM_W-1:0]   out_sym,
  output logic [MAX_LEN-1:0] out_code,
  output logic [LEN_W-1:0]   out_len,
  output logic               out_last,
  output logic               busy
);

  localparam int NODES  = 2 * NUM_SYM - 1;
  localparam int NODE_W = $clog2(NODES);
  localparam int LEAF_W = $clog2(NUM_SYM);
  localparam int SUM_W  = FREQ_W + $clog2(NUM_SYM);
  localparam int CNT_W  = $clog2(NUM_SYM + MAX_LEN + 1);

  localparam logic [CNT_W-1:0] LAST_LEAF  = CNT_W'(NUM_SYM - 1);
  localparam logic [CNT_W-1:0] LAST_MERGE = CNT_W'(NUM_SYM - 2);
  localparam logic [CNT_W-1:0] LAST_CANON = CNT_W'(MAX_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MERGE,
    S_DEPTH,
    S_CANON,
    S_EMIT
  } state_t;

  state_t state, next_state;

  // Node tables: leaves at 0..N-1, internal nodes at N..2N-2. Child pointers
  // are indexed by the parent's node number so leaf slots simply go unused.
  logic [SYM_W-1:0]   sym_tab   [NUM_SYM];
  logic [SUM_W-1:0]   freq_tab  [NODES];
  logic [NODE_W-1:0]  left_tab  [NODES];
  logic [NODE_W-1:0]  right_tab [NODES];
  logic [LEN_W-1:0]   depth_tab [NODES];
  logic [MAX_LEN-1:0] code_tab  [NUM_SYM];
  logic [NODES-1:0]   active;

  // Shared step counter: load index, merge step, depth step, canon length-1, emit index.
  logic [CNT_W-1:0]   cnt;
  logic [LEAF_W-1:0]  leaf_idx;

  // Canonical-code running state carried across lengths.
  logic [MAX_LEN-1:0] prev_code;
  logic [LEN_W-1:0]   prev_len;
  logic               have_prev;

  logic [NODE_W-1:0]  min1, min2, new_node, visit;
  logic               found1, found2;

  logic [MAX_LEN-1:0] code_next [NUM_SYM];
  logic [MAX_LEN-1:0] c_code;
  logic [LEN_W-1:0]   c_len, cur_len;
  logic               c_have;

  assign leaf_idx = cnt[LEAF_W-1:0];
  assign new_node = NODE_W'(NUM_SYM) + NODE_W'(cnt);
  assign visit    = NODE_W'(NODES - 1) - NODE_W'(cnt);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // Next-state logic and handshake/status outputs.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) next_state = S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && cnt == LAST_LEAF) next_state = S_MERGE;
      end
      S_MERGE: if (cnt == LAST_MERGE) next_state = S_DEPTH;
      S_DEPTH: if (cnt == LAST_MERGE) next_state = S_CANON;
      S_CANON: if (cnt == LAST_CANON) next_state = S_EMIT;
      S_EMIT: begin
        out_valid = 1'b1;
        if (out_ready && cnt == LAST_LEAF) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Pick the two smallest active nodes; strict '<' over ascending index breaks ties low.
  always_comb begin
    min1   = '0;
    min2   = '0;
    found1 = 1'b0;
    found2 = 1'b0;
    for (int i = 0; i < NODES; i++) begin
      if (active[i] && (!found1 || freq_tab[i] < freq_tab[min1])) begin
        min1   = NODE_W'(i);
        found1 = 1'b1;
      end
    end
    for (int i = 0; i < NODES; i++) begin
      if (active[i] && NODE_W'(i) != min1 && (!found2 || freq_tab[i] < freq_tab[min2])) begin
        min2   = NODE_W'(i);
        found2 = 1'b1;
      end
    end
  end

  // Assign canonical codes to every leaf of the current length, in leaf index order.
  always_comb begin
    c_code  = prev_code;
    c_len   = prev_len;
    c_have  = have_prev;
    cur_len = LEN_W'(cnt) + LEN_W'(1);
    for (int i = 0; i < NUM_SYM; i++) code_next[i] = code_tab[i];
    for (int i = 0; i < NUM_SYM; i++) begin
      if (depth_tab[i] == cur_len) begin
        if (c_have) c_code = (c_code + MAX_LEN'(1)) << (cur_len - c_len);
        else        c_code = '0;
        c_have       = 1'b1;
        c_len        = cur_len;
        code_next[i] = c_code;
      end
    end
  end

  // Datapath: table updates for each phase and the shared step counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SYM; i++) begin
        sym_tab[i]  <= '0;
        code_tab[i] <= '0;
      end
      for (int i = 0; i < NODES; i++) begin
        freq_tab[i]  <= '0;
        left_tab[i]  <= '0;
        right_tab[i] <= '0;
        depth_tab[i] <= '0;
      end
      active    <= '0;
      cnt       <= '0;
      prev_code <= '0;
      prev_len  <= '0;
      have_prev <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          active <= NODES'(1);
          for (int i = 0; i < NODES; i++) depth_tab[i] <= '0;
          sym_tab[0]  <= in_sym;
          freq_tab[0] <= SUM_W'(in_freq);
          have_prev   <= 1'b0;
          cnt         <= CNT_W'(1);
        end
        S_LOAD: if (in_valid) begin
          sym_tab[leaf_idx]              <= in_sym;
          freq_tab[NODE_W'(leaf_idx)]    <= SUM_W'(in_freq);
          active[NODE_W'(leaf_idx)]      <= 1'b1;
          cnt <= (cnt == LAST_LEAF) ? '0 : cnt + CNT_W'(1);
        end
        S_MERGE: begin
          freq_tab[new_node]  <= freq_tab[min1] + freq_tab[min2];
          left_tab[new_node]  <= min1;
          right_tab[new_node] <= min2;
          active[min1]        <= 1'b0;
          active[min2]        <= 1'b0;
          active[new_node]    <= 1'b1;
          cnt <= (cnt == LAST_MERGE) ? '0 : cnt + CNT_W'(1);
        end
        S_DEPTH: begin
          // Parents always carry higher indices than children, so a descending
          // walk sees each node's depth settled before it is propagated.
          depth_tab[left_tab[visit]]  <= depth_tab[visit] + LEN_W'(1);
          depth_tab[right_tab[visit]] <= depth_tab[visit] + LEN_W'(1);
          cnt <= (cnt == LAST_MERGE) ? '0 : cnt + CNT_W'(1);
        end
        S_CANON: begin
          for (int i = 0; i < NUM_SYM; i++) code_tab[i] <= code_next[i];
          prev_code <= c_code;
          prev_len  <= c_len;
          have_prev <= c_have;
          cnt <= (cnt == LAST_CANON) ? '0 : cnt + CNT_W'(1);
        end
        S_EMIT: if (out_ready) begin
          cnt <= (cnt == LAST_LEAF) ? '0 : cnt + CNT_W'(1);
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Output entry mux; zero whenever no entry is being offered.
  always_comb begin
    out_sym  = '0;
    out_code = '0;
    out_len  = '0;
    out_last = 1'b0;
    if (out_valid) begin
      out_sym  = sym_tab[leaf_idx];
      out_code = code_tab[leaf_idx];
      out_len  = depth_tab[NODE_W'(leaf_idx)];
      out_last = (cnt == LAST_LEAF);
    end
  end

endmodule

// File: tb/tb_huff_code_gen.sv
// tb/tb_huff_code_gen.sv - self-checking bench for huff_code_gen with a queue-based Huffman model
module tb_huff_code_gen;
  localparam int N  = 4;
  localparam int ML = N - 1;

  logic       clk, reset_n, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [7:0] in_sym, in_freq, out_sym;
  logic [2:0] out_code;
  logic [1:0] out_len;

  int         checks, errors;
  int         blk_freq [N];
  logic [7:0] blk_sym  [N];
  int         exp_code [N];
  int         exp_len  [N];

  huff_code_gen #(.NUM_SYM(N), .SYM_W(8), .FREQ_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym), .in_freq(in_freq),
    .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym),
    .out_code(out_code), .out_len(out_len), .out_last(out_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Huffman reference: sorted queue of (freq, index), merged two at a time;
  // lengths from parent walks; codes from per-length counts.
  task automatic model();
    int f   [2*N-1];
    int par [2*N-1];
    int q[$];
    int bl  [ML+1];
    int nxt [ML+1];
    int a, b, pos, nd, d, code;
    for (int i = 0; i < 2*N-1; i++) begin f[i] = 0; par[i] = -1; end
    q = {};
    for (int i = 0; i < N; i++) begin
      f[i] = blk_freq[i];
      pos = 0;
      while (pos < q.size() && f[q[pos]] <= f[i]) pos++;
      q.insert(pos, i);
    end
    for (int m = 0; m < N-1; m++) begin
      a = q.pop_front();
      b = q.pop_front();
      nd = N + m;
      f[nd] = f[a] + f[b];
      par[a] = nd;
      par[b] = nd;
      pos = 0;
      while (pos < q.size() && f[q[pos]] <= f[nd]) pos++;
      q.insert(pos, nd);
    end
    for (int i = 0; i <= ML; i++) bl[i] = 0;
    for (int i = 0; i < N; i++) begin
      d = 0;
      nd = i;
      while (par[nd] >= 0) begin nd = par[nd]; d++; end
      exp_len[i] = d;
      bl[d]++;
    end
    code = 0;
    nxt[0] = 0;
    for (int l = 1; l <= ML; l++) begin
      code = (code + bl[l-1]) << 1;
      nxt[l] = code;
    end
    for (int i = 0; i < N; i++) begin
      exp_code[i] = nxt[exp_len[i]];
      nxt[exp_len[i]]++;
    end
  endtask

  task automatic set_block(input int f0, input int f1, input int f2, input int f3);
    blk_freq[0] = f0; blk_freq[1] = f1; blk_freq[2] = f2; blk_freq[3] = f3;
    for (int i = 0; i < N; i++) blk_sym[i] = 8'h41 + 8'(i);
  endtask

  task automatic send(input logic [7:0] s, input logic [7:0] f);
    int n;
    in_valid = 1'b1;
    in_sym   = s;
    in_freq  = f;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    if (n >= 100) chk("in_ready_timeout", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load_all(input int gap_max);
    for (int i = 0; i < N; i++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) begin
          tick();
          if (i > 0) chk("busy_gap", 32'(busy), 1);
        end
      end
      send(blk_sym[i], 8'(blk_freq[i]));
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      chk("busy_wait", 32'(busy), 1);
      chk("in_ready_wait", 32'(in_ready), 0);
      tick();
      lat++;
    end
  endtask

  task automatic run_block(input int gap_max, input bit stall);
    int lat, idx, budget;
    bit held;
    logic [7:0] hs;
    logic [2:0] hc;
    logic [1:0] hl;
    model();
    load_all(gap_max);
    wait_out(lat);
    chk("latency", 32'(lat), 32'(3*(N-1)));
    idx = 0; budget = 0; held = 0;
    hs = '0; hc = '0; hl = '0;
    while (idx < N && budget < 300) begin
      chk("out_valid_hold", 32'(out_valid), 1);
      chk("in_ready_emit", 32'(in_ready), 0);
      chk("busy_emit", 32'(busy), 1);
      if (stall) in_valid = 1'($urandom_range(0, 1));
      if (out_valid) begin
        if (held) begin
          chk("stall_sym", 32'(out_sym), 32'(hs));
          chk("stall_code", 32'(out_code), 32'(hc));
          chk("stall_len", 32'(out_len), 32'(hl));
        end
        out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_ready) begin
          chk("out_sym", 32'(out_sym), 32'(blk_sym[idx]));
          chk("out_code", 32'(out_code), 32'(exp_code[idx]));
          chk("out_len", 32'(out_len), 32'(exp_len[idx]));
          chk("out_last", 32'(out_last), 32'(idx == N-1));
          idx++;
          held = 0;
        end else begin
          held = 1;
          hs = out_sym; hc = out_code; hl = out_len;
        end
      end
      tick();
      budget++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("emit_count", 32'(idx), 32'(N));
    chk("done_out_valid", 32'(out_valid), 0);
    chk("done_in_ready", 32'(in_ready), 1);
    chk("done_busy", 32'(busy), 0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_last"}, 32'(out_last), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_out_sym"}, 32'(out_sym), 0);
    chk({tag, "_out_code"}, 32'(out_code), 0);
    chk({tag, "_out_len"}, 32'(out_len), 0);
  endtask

  initial begin
    int lat;
    checks = 0; errors = 0;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_sym = '0; in_freq = '0;
    tick();
    tick();
    check_reset("rst");
    reset_n = 1'b1;
    tick();

    set_block(5, 1, 1, 2);  run_block(0, 0);   // T1
    set_block(1, 1, 1, 1);  run_block(0, 0);   // T2
    set_block(1, 2, 4, 8);  run_block(0, 0);   // T3
    set_block(5, 1, 1, 2);  run_block(0, 1);   // T4

    // T5: reset during MERGE, then during EMIT, then a clean T2 block.
    set_block(5, 1, 1, 2);
    load_all(0);
    tick();
    reset_n = 1'b0;
    tick();
    check_reset("rst_merge");
    reset_n = 1'b1;
    load_all(0);
    wait_out(lat);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    reset_n = 1'b0;
    tick();
    check_reset("rst_emit");
    reset_n = 1'b1;
    tick();
    set_block(1, 1, 1, 1);  run_block(0, 0);

    set_block(0, 0, 0, 0);  run_block(3, 0);   // T6

    for (int r = 0; r < 8; r++) begin
      if (r % 2 == 0)
        set_block($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        set_block($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      run_block(2, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
